// File: rtl/ibex_multdiv_iter.sv
// Iterative multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with optional early termination.
module ibex_multdiv_iter #(
    parameter int Width     = 32,
    parameter bit EarlyTerm = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [1:0]       operator_i,
    input  logic [1:0]       signed_mode_i,
    input  logic [Width-1:0] op_a_i,
    input  logic [Width-1:0] op_b_i,
    input  logic             data_ind_timing_i,
    input  logic             kill_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [Width-1:0] result_o
);

    localparam int CW = $clog2(Width + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;
    typedef enum logic [1:0] {OP_MUL, OP_MULH, OP_DIV, OP_REM} op_e;

    state_e               state;
    op_e                  op_q;
    logic                 neg_a_q, neg_b_q, dit_q, div_zero_q, div_ovf_q;
    logic [Width-1:0]     op_a_q;
    logic [CW-1:0]        cnt;
    logic [2*Width-1:0]   acc, mcand;
    logic [Width-1:0]     shreg, rem, mag_b;

    logic                 a_neg_in, b_neg_in, mul_in, div_zero_in, div_ovf_in;
    logic [Width-1:0]     a_mag_in, b_mag_in;
    logic                 is_mul, last, early, div_ge;
    logic [2*Width-1:0]   acc_add, prod;
    logic [Width:0]       div_shift;
    logic [Width-1:0]     div_sub, quo_fix, rem_fix, fix_res;

    always_comb begin
        a_neg_in    = signed_mode_i[0] & op_a_i[Width-1];
        b_neg_in    = signed_mode_i[1] & op_b_i[Width-1];
        a_mag_in    = a_neg_in ? -op_a_i : op_a_i;
        b_mag_in    = b_neg_in ? -op_b_i : op_b_i;
        mul_in      = ~operator_i[1];
        div_zero_in = (op_b_i == '0);
        div_ovf_in  = (&signed_mode_i) & (&op_b_i)
                    & (op_a_i == {1'b1, {(Width-1){1'b0}}});
    end

    // shreg holds the multiplier (shifting right) or the dividend/quotient (shifting left)
    always_comb begin
        is_mul    = (op_q == OP_MUL) || (op_q == OP_MULH);
        acc_add   = shreg[0] ? acc + mcand : acc;
        div_shift = {rem, shreg[Width-1]};
        div_ge    = (div_shift >= {1'b0, mag_b});
        div_sub   = div_shift[Width-1:0] - mag_b;
        last      = (cnt == CW'(1));
        early     = !dit_q && (is_mul ? (EarlyTerm && (shreg[Width-1:1] == '0))
                                      : (div_zero_q || div_ovf_q));
    end

    always_comb begin
        prod    = (neg_a_q ^ neg_b_q) ? -acc : acc;
        quo_fix = (neg_a_q ^ neg_b_q) ? -shreg : shreg;
        rem_fix = neg_a_q ? -rem : rem;
        fix_res = '0;
        unique case (op_q)
            OP_MUL:  fix_res = prod[Width-1:0];
            OP_MULH: fix_res = prod[2*Width-1:Width];
            OP_DIV:  fix_res = div_zero_q ? '1 : (div_ovf_q ? op_a_q : quo_fix);
            OP_REM:  fix_res = div_zero_q ? op_a_q : (div_ovf_q ? '0 : rem_fix);
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            ready_o    <= 1'b1;
            valid_o    <= 1'b0;
            result_o   <= '0;
            op_q       <= OP_MUL;
            neg_a_q    <= 1'b0;
            neg_b_q    <= 1'b0;
            dit_q      <= 1'b0;
            div_zero_q <= 1'b0;
            div_ovf_q  <= 1'b0;
            op_a_q     <= '0;
            cnt        <= '0;
            acc        <= '0;
            mcand      <= '0;
            shreg      <= '0;
            rem        <= '0;
            mag_b      <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        state      <= CALC;
                        ready_o    <= 1'b0;
                        op_q       <= op_e'(operator_i);
                        neg_a_q    <= a_neg_in;
                        neg_b_q    <= b_neg_in;
                        dit_q      <= data_ind_timing_i;
                        div_zero_q <= div_zero_in;
                        div_ovf_q  <= div_ovf_in;
                        op_a_q     <= op_a_i;
                        cnt        <= CW'(Width);
                        acc        <= '0;
                        mcand      <= {{Width{1'b0}}, a_mag_in};
                        shreg      <= mul_in ? b_mag_in : a_mag_in;
                        rem        <= '0;
                        mag_b      <= b_mag_in;
                    end
                end
                CALC: begin
                    if (kill_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        if (is_mul) begin
                            acc   <= acc_add;
                            mcand <= mcand << 1;
                            shreg <= shreg >> 1;
                        end else begin
                            rem   <= div_ge ? div_sub : div_shift[Width-1:0];
                            shreg <= {shreg[Width-2:0], div_ge};
                        end
                        cnt <= cnt - CW'(1);
                        if (last || early) state <= FIX;
                    end
                end
                FIX: begin
                    if (kill_i) begin
                        state   <= IDLE;
                        ready_o <= 1'b1;
                    end else begin
                        state    <= DONE;
                        valid_o  <= 1'b1;
                        result_o <= fix_res;
                    end
                end
                DONE: begin
                    if (kill_i || ready_i) begin
                        state    <= IDLE;
                        ready_o  <= 1'b1;
                        valid_o  <= 1'b0;
                        result_o <= '0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ibex_multdiv_iter.sv
// Self-checking bench for ibex_multdiv_iter (Width=32) against an arithmetic
// reference model; latency counts cycles from acceptance until valid_o is seen.
module tb_ibex_multdiv_iter;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [1:0]  operator_i = '0;
    logic [1:0]  signed_mode_i = '0;
    logic [31:0] op_a_i = '0;
    logic [31:0] op_b_i = '0;
    logic        data_ind_timing_i = 1'b0;
    logic        kill_i = 1'b0;
    logic        valid_o;
    logic        ready_i = 1'b0;
    logic [31:0] result_o;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ibex_multdiv_iter #(.Width(32), .EarlyTerm(1'b1)) dut (
        .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
        .operator_i(operator_i), .signed_mode_i(signed_mode_i),
        .op_a_i(op_a_i), .op_b_i(op_b_i), .data_ind_timing_i(data_ind_timing_i),
        .kill_i(kill_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [1:0] sm,
                                            input logic [31:0] a, input logic [31:0] b);
        longint av, bv, p;
        av = sm[0] ? longint'($signed(a)) : longint'({32'b0, a});
        bv = sm[1] ? longint'($signed(b)) : longint'({32'b0, b});
        p = av * bv;
        case (op)
            2'd0: return p[31:0];
            2'd1: return p[63:32];
            2'd2: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                return 32'(av / bv);
            end
            default: begin
                if (b == 32'd0) return a;
                if (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(av % bv);
            end
        endcase
    endfunction

    function automatic int ref_lat(input logic [1:0] op, input logic [1:0] sm,
                                   input logic [31:0] a, input logic [31:0] b, input logic dit);
        logic [31:0] bm;
        int bits;
        if (dit) return 34;
        if (op[1]) begin
            if (b == 32'd0 || (sm == 2'b11 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))
                return 3;
            return 34;
        end
        bm = (sm[1] && b[31]) ? -b : b;
        bits = 1;
        for (int i = 0; i < 32; i++) if (bm[i]) bits = i + 1;
        return bits + 2;
    endfunction

    task automatic wait_ready(input string tag);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready_o) chk({tag, "_ready_timeout"}, 0, 1);
    endtask

    // One transaction; noise keeps valid_i asserted with other operands while busy,
    // hold keeps ready_i low for 10 cycles in DONE.
    task automatic do_op(input string tag, input logic [1:0] op, input logic [1:0] sm,
                         input logic [31:0] a, input logic [31:0] b, input logic dit,
                         input logic kill_acc, input logic noise, input logic hold);
        int lat;
        logic [31:0] exp_r;
        exp_r = ref_res(op, sm, a, b);
        wait_ready(tag);
        valid_i = 1'b1; operator_i = op; signed_mode_i = sm;
        op_a_i = a; op_b_i = b; data_ind_timing_i = dit; kill_i = kill_acc;
        @(posedge clk);
        #1;
        kill_i = 1'b0;
        valid_i = noise;
        op_a_i = ~a; op_b_i = b + 32'd3; operator_i = ~op; data_ind_timing_i = ~dit;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!valid_o && lat < 100);
        valid_i = 1'b0;
        chk({tag, "_latency"}, 64'(lat), 64'(ref_lat(op, sm, a, b, dit)));
        chk({tag, "_result"}, {32'b0, result_o}, {32'b0, exp_r});
        if (hold) begin
            for (int i = 0; i < 10; i++) begin
                @(negedge clk);
                chk({tag, "_hold"}, {31'b0, valid_o, result_o}, {31'b0, 1'b1, exp_r});
            end
        end
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        ready_i = 1'b0;
        @(negedge clk);
        chk({tag, "_after"}, {30'b0, valid_o, ready_o, result_o}, {30'b0, 1'b0, 1'b1, 32'd0});
    endtask

    task automatic no_valid_for(input string tag, input int cycles);
        logic seen = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (valid_o) seen = 1'b1;
        end
        chk({tag, "_no_result"}, {63'b0, seen}, 64'd0);
    endtask

    initial begin
        logic [1:0]  rop, rsm;
        logic [31:0] ra, rb;
        logic        rdit;

        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk("reset_state", {30'b0, ready_o, valid_o, result_o}, {30'b0, 1'b1, 1'b0, 32'd0});

        do_op("mul_7x6", 2'd0, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mulh_7x6", 2'd1, 2'b00, 32'd7, 32'd6, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mulh_s_m2x3", 2'd1, 2'b11, 32'hFFFF_FFFE, 32'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("div_s_m7_2", 2'd2, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("rem_s_m7_2", 2'd3, 2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("div_5_0", 2'd2, 2'b00, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("rem_5_0_dit", 2'd3, 2'b00, 32'd5, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("div_ovf", 2'd2, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("rem_ovf", 2'd3, 2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
        do_op("mul_b0", 2'd0, 2'b11, 32'h1234_5678, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        do_op("mul_hold", 2'd0, 2'b01, 32'hFFFF_FF00, 32'd300, 1'b0, 1'b0, 1'b0, 1'b1);
        do_op("div_busy_noise", 2'd2, 2'b00, 32'd1000, 32'd7, 1'b0, 1'b0, 1'b1, 1'b0);
        do_op("kill_idle_accept", 2'd0, 2'b00, 32'd11, 32'd13, 1'b1, 1'b1, 1'b0, 1'b0);

        // kill during the fifth CALC cycle
        wait_ready("kill");
        valid_i = 1'b1; operator_i = 2'd0; signed_mode_i = 2'b00;
        op_a_i = 32'd9; op_b_i = 32'hFFFF_FFFF; data_ind_timing_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (5) @(negedge clk);
        kill_i = 1'b1;
        @(posedge clk);
        #1 kill_i = 1'b0;
        @(negedge clk);
        chk("kill_outputs", {30'b0, ready_o, valid_o, result_o}, {30'b0, 1'b1, 1'b0, 32'd0});
        no_valid_for("kill", 40);

        // reset mid-CALC with every other control input asserted
        wait_ready("rst");
        valid_i = 1'b1; operator_i = 2'd2; op_a_i = 32'd12345; op_b_i = 32'd17;
        data_ind_timing_i = 1'b1;
        @(posedge clk);
        #1 valid_i = 1'b0;
        repeat (7) @(negedge clk);
        rst_i = 1'b1; valid_i = 1'b1; ready_i = 1'b1; kill_i = 1'b1;
        @(posedge clk);
        #1;
        rst_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0; kill_i = 1'b0;
        @(negedge clk);
        chk("rst_mid_outputs", {30'b0, ready_o, valid_o, result_o}, {30'b0, 1'b1, 1'b0, 32'd0});
        no_valid_for("rst_mid", 40);

        for (int i = 0; i < 40; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rsm  = 2'($urandom_range(0, 3));
            rdit = 1'($urandom_range(0, 1));
            ra   = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(0, 255));
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
                default: rb = $urandom;
            endcase
            do_op("random", rop, rsm, ra, rb, rdit, 1'(i % 7 == 3), 1'(i % 5 == 1), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
